// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the countdown timer path: digit width,
// state encoding and a preset validity check.
package bcd_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // True when every one of the low `digits` nibbles of v is 0..9 (up to 16 digits).
    function automatic logic is_valid_bcd(input logic [63:0] v, input int digits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if ((i < digits) && (v[i*4 +: 4] > BCD_MAX)) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the decrement chain: 0 with a borrow becomes 9 and
// passes the borrow on to the next digit.
module bcd_digit_dec
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit_in,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] digit_out,
    output logic             borrow_out
);

    // Decrement when borrowed from, wrapping 0 to 9.
    always_comb begin
        digit_out  = digit_in;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit_in == 4'd0) begin
                digit_out  = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                digit_out  = digit_in - 4'd1;
                borrow_out = 1'b0;
            end
        end else begin
            digit_out  = digit_in;
            borrow_out = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_countdown.sv
// Loadable multi-digit BCD down-counter with prescaler, pause and a
// one-cycle done pulse when the count reaches zero.
module bcd_countdown
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*DIGITS-1:0] preset,
    input  logic                start,
    input  logic                pause,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int            W        = BCD_W * DIGITS;
    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [W-1:0]  dec_s;
    logic [DIGITS:0] borrow_s;
    logic          terminal_s;

    assign borrow_s[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit_dec u_dec (
            .digit_in  (cnt_q[g*BCD_W +: BCD_W]),
            .borrow_in (borrow_s[g]),
            .digit_out (dec_s[g*BCD_W +: BCD_W]),
            .borrow_out(borrow_s[g+1])
        );
    end

    // A borrow out of the top digit would mean wrapping below zero; treat it as terminal too.
    assign terminal_s = (dec_s == '0) || borrow_s[DIGITS];

    // Next-state logic for the IDLE/RUN/HOLD controller and counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    if (is_valid_bcd(64'(preset), DIGITS)) begin
                        cnt_d = preset;
                        err_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (start && !err_q) begin
                    if (cnt_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                        pre_d   = '0;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            // Leaving HOLD resumes counting on the same edge, so a pause costs exactly its length.
            ST_RUN, ST_HOLD: begin
                if (pause) begin
                    state_d = ST_HOLD;
                end else if (pre_q != PRE_LAST) begin
                    state_d = ST_RUN;
                    pre_d   = pre_q + PW'(1);
                end else if (terminal_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    pre_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = dec_s;
                    pre_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pre_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bcd_out = cnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed bench for bcd_countdown: IDLE vector table plus hand sequences
// for countdown, borrow, pause timing and asynchronous reset.
module tb_bcd_countdown;
    import bcd_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       load1, start1, pause1;
    logic [7:0] preset1, bcd1;
    logic       busy1, done1, err1;
    logic       load4, start4, pause4;
    logic [7:0] preset4, bcd4;
    logic       busy4, done4, err4;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    bcd_countdown #(.DIGITS(2), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .load(load1), .preset(preset1), .start(start1),
        .pause(pause1), .bcd_out(bcd1), .busy(busy1), .done(done1), .err(err1)
    );

    bcd_countdown #(.DIGITS(2), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .load(load4), .preset(preset4), .start(start4),
        .pause(pause4), .bcd_out(bcd4), .busy(busy4), .done(done4), .err(err4)
    );

    typedef struct {
        logic       load;
        logic       start;
        logic [7:0] preset;
        logic [7:0] e_bcd;
        logic       e_busy;
        logic       e_done;
        logic       e_err;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic run_count(input int n, input string tag);
        load1 = 1'b1; preset1 = to_bcd(n);
        tick();
        load1 = 1'b0;
        chk({tag, "_load"}, bcd1, to_bcd(n));
        chk({tag, "_err"}, err1, 1'b0);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk({tag, "_busy_rise"}, busy1, 1'b1);
        for (int i = 1; i <= n; i++) begin
            tick();
            chk({tag, "_bcd"}, bcd1, to_bcd(n - i));
            chk({tag, "_done"}, done1, (i == n) ? 1'b1 : 1'b0);
            chk({tag, "_busy"}, busy1, (i < n) ? 1'b1 : 1'b0);
            chk({tag, "_nib"}, (bcd1[3:0] <= 4'd9) && (bcd1[7:4] <= 4'd9), 1'b1);
        end
        tick();
        chk({tag, "_done_clear"}, done1, 1'b0);
    endtask

    // Edges from the start edge until done; 0 if done never arrives.
    task automatic time_run(input int pause_at, input int pause_len, output int edges);
        edges = 0;
        load4 = 1'b1; preset4 = 8'h03;
        tick();
        load4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int e = 1; e <= 100; e++) begin
            if (pause_len > 0 && e == pause_at + 1) pause4 = 1'b1;
            if (pause_len > 0 && e == pause_at + 1 + pause_len) pause4 = 1'b0;
            tick();
            if (pause4) begin
                chk("hold_bcd", bcd4, 8'h03);
                chk("hold_busy", busy4, 1'b1);
                chk("hold_pre", dut4.pre_q, 2'd2);
            end
            if (done4) begin
                edges = e;
                break;
            end
        end
        tick();
        chk("p4_done_clear", done4, 1'b0);
    endtask

    initial begin
        int t_plain, t_pause;
        rst = 1'b0;
        load1 = 1'b0; start1 = 1'b0; pause1 = 1'b0; preset1 = 8'h00;
        load4 = 1'b0; start4 = 1'b0; pause4 = 1'b0; preset4 = 8'h00;
        #12;
        chk("rst_bcd", bcd1, 8'h00);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_done", done1, 1'b0);
        chk("rst_err", err1, 1'b0);
        rst = 1'b1;
        tick();

        tbl[0]  = '{1'b1, 1'b0, 8'h12, 8'h12, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8'h02, 8'h02, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h1A, 8'h02, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'hA0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 8'h99, 8'h99, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            load1 = tbl[i].load; start1 = tbl[i].start; preset1 = tbl[i].preset;
            tick();
            chk($sformatf("vec%0d_bcd", i), bcd1, tbl[i].e_bcd);
            chk($sformatf("vec%0d_busy", i), busy1, tbl[i].e_busy);
            chk($sformatf("vec%0d_done", i), done1, tbl[i].e_done);
            chk($sformatf("vec%0d_err", i), err1, tbl[i].e_err);
        end
        load1 = 1'b0; start1 = 1'b0;

        run_count(12, "cnt12");
        run_count(10, "borrow10");

        load1 = 1'b1; preset1 = 8'h34;
        tick();
        preset1 = 8'h1A;
        tick();
        load1 = 1'b0;
        chk("inv_err", err1, 1'b1);
        chk("inv_keep", bcd1, 8'h34);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("inv_start_busy", busy1, 1'b0);
        chk("inv_start_bcd", bcd1, 8'h34);
        run_count(5, "cnt05");

        time_run(2, 0, t_plain);
        chk("p4_plain_edges", t_plain, 12);
        time_run(2, 10, t_pause);
        chk("p4_pause_edges", t_pause, 22);

        load1 = 1'b1; preset1 = 8'h05;
        tick();
        load1 = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0; load1 = 1'b1; preset1 = 8'h99;
        tick();
        load1 = 1'b0;
        chk("runload_bcd", bcd1, 8'h04);
        chk("runload_busy", busy1, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        chk("runload_end", bcd1, 8'h00);
        chk("runload_done", done1, 1'b1);

        load1 = 1'b1; preset1 = 8'h09;
        tick();
        load1 = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        chk("ar_pre_bcd", bcd1, 8'h07);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_bcd", bcd1, 8'h00);
        chk("ar_busy", busy1, 1'b0);
        chk("ar_done", done1, 1'b0);
        #1;
        rst = 1'b1;
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("zero_done", done1, 1'b1);
        chk("zero_busy", busy1, 1'b0);
        tick();
        chk("zero_done_clear", done1, 1'b0);
        chk("zero_idle", busy1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bcd_countdown.md
Name: bcd_countdown

Overview:
- Loadable multi-digit BCD down-counter. It is the counting-down counterpart to the team's up-counting bcdsync block.
- Software or a control FSM presets a BCD value and issues start. The block decrements once per prescaled tick, then pulses done at 00..0.
- It sits beside bcdsync in the timer/display path and drives the same 4-bit-per-digit BCD bus format to the display decoders.

Parameters:
- DIGITS, 2, number of BCD digits; bus width is 4*DIGITS; digit 0 is the least significant, in bits [3:0].
- PRESCALE, 1, clock cycles per decrement; must be >= 1; PRESCALE=1 means one decrement every clock.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- load  in  1  capture preset; honoured only in IDLE.
- preset  in  4*DIGITS  BCD value to load.
- start  in  1  begin countdown; honoured only in IDLE.
- pause  in  1  level; freezes the countdown while high.
- bcd_out  out  4*DIGITS  current count; each nibble is always 0..9.
- busy  out  1  high in RUN and HOLD.
- done  out  1  one-cycle pulse when the count reaches zero.
- err  out  1  sticky flag: last load attempt had a nibble > 9.

Behaviour:
- Reset (rst=0, asynchronous): bcd_out=0, busy=0, done=0, err=0, prescaler=0, state=IDLE. Outputs are registered.
- States are IDLE, RUN and HOLD. done is a registered pulse, not a state.

IDLE:
- load=1 and every preset nibble <= 9: bcd_out<=preset and err<=0 on the next edge.
- load=1 and any nibble > 9: bcd_out is unchanged and err<=1. err stays set until the next valid load or a reset.
- load and start in the same cycle: load wins and start is ignored.
- start=1 with err=0 and bcd_out != 0: go to RUN, busy<=1, prescaler<=0.
- start=1 with bcd_out == 0: done pulses on the next edge; the block stays in IDLE and busy stays 0.
- start=1 with err=1: ignored.

RUN:
- The prescaler counts 0..PRESCALE-1. At the terminal count the value decrements and the prescaler returns to 0.
- Decrement rule: if digit 0 is not 0, it decrements. If it is 0, it becomes 9 and borrows into the next digit, rippling through all DIGITS.
- The decrement from value 1 to 0 happens in a single edge: bcd_out<=0, busy<=0, done<=1 (for exactly one cycle), state<=IDLE.
- The count never wraps below 0.
- load and start are ignored while in RUN.
- Timing: start is sampled at edge k and the preset is N. Then bcd_out steps every PRESCALE edges, and done/busy-fall occur at edge k+N*PRESCALE.

HOLD:
- pause=1 in RUN moves to HOLD on the next edge. pause=1 takes priority over the decrement due on that same edge, so no step occurs on that edge.
- In HOLD the prescaler and bcd_out are frozen and busy stays 1.
- pause=0 returns to RUN and the prescaler resumes from its frozen value.
- load and start are ignored in HOLD.

Other rules:
- rst asserted mid-RUN or mid-HOLD clears everything immediately, without waiting for a clock edge.
- done is 0 in every cycle except the terminal pulse.

Decomposition:
- Shared package bcd_pkg holds:
  - the BCD digit width constant (4);
  - BCD_MAX = 4'd9;
  - the state encoding (IDLE, RUN, HOLD);
  - a function is_valid_bcd(vector) used for the preset check and by benches.
- Sub-module bcd_digit_dec: one digit's combinational decrement with borrow_in and borrow_out. It is instantiated DIGITS times in a generate loop, chained through the borrows.

Test Plan:
1. Reset, then load preset=8'h12, start, PRESCALE=1 -> bcd_out goes 12,11,10,09,...,01,00. done is high for exactly 1 cycle at edge start+12, busy falls on the same edge, and no nibble ever exceeds 9.
2. Borrow chain: DIGITS=2, preset=8'h10, start -> the sequence is 10, then 09 (not 0F), continuing down to 00; done after 10 steps.
3. Invalid load: preset=8'h1A -> err=1 and bcd_out keeps its old value. A following start is ignored. Then load 8'h05 -> err=0, and start counts 05 down to 00.
4. Pause: PRESCALE=4, preset=8'h03, pause high for 10 cycles mid-count -> bcd_out and the prescaler are frozen and busy stays 1. done lands exactly 10 cycles later than in the unpaused run.
5. Async reset mid-run: rst=0 between clock edges while bcd_out=8'h07 -> bcd_out=0, busy=0 and done=0 immediately, before the next edge. After release, start with value 0 -> a single done pulse and no RUN.
6. Same-cycle load+start in IDLE: preset=8'h02 -> the value loads and busy stays 0. A load asserted during RUN is ignored and the count continues.
